// File: rtl/rot_pkg.sv
// Shared constants, FSM state type and amount helper for the rotate burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rot_pkg;

  // Data width is tied to the rotate stage; the amount is log2 of it.
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int CNT_W  = 4;

  // IDLE waits for a command, RUN streams beats of the current command.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A left rotate by n equals a right rotate by (-n) mod DATA_W.
  function automatic logic [AMT_W-1:0] neg_amt(input logic [AMT_W-1:0] amt);
    logic [AMT_W-1:0] zero;
    zero = '0;
    return zero - amt;
  endfunction

endpackage

// File: rtl/barrel_shifter_stage_r.sv
// Combinational right-rotate of DATA_W bits by amt_i (log2 stages).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller registers the result.
module barrel_shifter_stage_r #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  // Each amount bit i conditionally rotates right by 2^i.
  always_comb begin
    logic [DATA_W-1:0] tmp;
    tmp = data_i;
    for (int i = 0; i < AMT_W; i++) begin
      if (amt_i[i]) begin
        tmp = (tmp >> (1 << i)) | (tmp << (DATA_W - (1 << i)));
      end
    end
    data_o = tmp;
  end

endmodule

// File: rtl/rot_burst_seq.sv
// Sequencer feeding one rotate stage: each command yields in_count+1 beats, beat k = data rotated by k*amt.
// Latency: first beat visible the cycle after accept, then one beat per cycle.
// Backpressure: outputs hold while out_ready is low; in_ready follows out_ready combinationally on the last beat.
// Optional: define ROT_BURST_LEFT_EN to honour in_dir (left rotate); otherwise in_dir is ignored.
module rot_burst_seq #(
  parameter int DATA_W = rot_pkg::DATA_W,
  parameter int AMT_W  = rot_pkg::AMT_W,
  parameter int CNT_W  = rot_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  import rot_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q,   rem_d;
  logic [AMT_W-1:0]  step_q,  step_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              vld_q,   vld_d;
  logic              last_q,  last_d;

  logic              rem_zero;
  logic              accept;
  logic              beat_taken;
  logic [AMT_W-1:0]  eff_amt;
  logic [DATA_W-1:0] rot_in;
  logic [AMT_W-1:0]  rot_amt;
  logic [DATA_W-1:0] rot_out;

  assign rem_zero   = (rem_q == '0);
  // A new command may enter while the final beat is being consumed, so no bubble between bursts.
  assign in_ready   = (state_q == IDLE) | ((state_q == RUN) & rem_zero & out_ready);
  assign accept     = in_valid & in_ready;
  assign beat_taken = vld_q & out_ready;

`ifdef ROT_BURST_LEFT_EN
  assign eff_amt = in_dir ? neg_amt(in_amt) : in_amt;
`else
  // Direction input is accepted but has no effect in the right-only build.
  logic unused_dir;
  assign unused_dir = in_dir;
  assign eff_amt    = in_amt;
`endif

  // The single rotate stage serves both the first beat (from the command) and later beats (from the output register).
  assign rot_in  = accept ? in_data : data_q;
  assign rot_amt = accept ? eff_amt : step_q;

  barrel_shifter_stage_r #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_rot (
    .data_i (rot_in),
    .amt_i  (rot_amt),
    .data_o (rot_out)
  );

  // Next-state: load on accept, advance on a consumed non-final beat, drop to IDLE after the final beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    step_d  = step_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;

    if (accept) begin
      step_d  = eff_amt;
      data_d  = rot_out;
      rem_d   = in_count;
      vld_d   = 1'b1;
      last_d  = (in_count == '0);
      state_d = RUN;
    end else if ((state_q == RUN) && beat_taken) begin
      if (!rem_zero) begin
        data_d = rot_out;
        rem_d  = rem_q - CNT_ONE;
        last_d = (rem_q == CNT_ONE);
      end else begin
        vld_d   = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: doc/rot_burst_seq.md
Name: rot_burst_seq

Overview:
- Upstream sequencer for the 8-bit right-rotate stage.
- Accepts a rotate command (data, amount, repeat count) over a valid/ready handshake and feeds the shared rotate stage.
- Emits a registered stream of count+1 results; beat k is the data rotated by k*amt (mod 8).
- Sits between a command source (e.g. switch/UART decoder) and the LED/display consumer.

Parameters:
- DATA_W, 8, data width; fixed at 8 to match the rotate stage.
- AMT_W, 3, rotate amount width, log2(DATA_W).
- CNT_W, 4, repeat-count width; max 2^CNT_W beats per command.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready.
- in_data  in  DATA_W  byte to rotate.
- in_amt  in  AMT_W  rotate step per beat.
- in_dir  in  1  0 = right, 1 = left (see Optional Feature).
- in_count  in  CNT_W  extra beats; emits in_count+1 results.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  DATA_W  rotated result, registered.
- out_last  out  1  high with the final beat of a command.

Behaviour:
Interface:
- One clock, clk.
- Reset is synchronous and active-low: reset_n, sampled on the rising edge of clk.

Reset:
- state = IDLE; out_valid, out_last, out_data, rem, step all 0.
- Reset mid-burst abandons the burst; no further beats are emitted.

FSM:
- IDLE: in_ready = 1. On accept: step <= effective amount; out_data <= rot(in_data, step); rem <= in_count; out_valid <= 1; out_last <= (in_count == 0); state -> RUN.
- RUN, out_valid & out_ready & rem != 0: out_data <= rot(out_data, step); rem <= rem - 1; out_last <= (rem == 1).
- RUN, out_valid & out_ready & rem == 0: out_valid <= 0; out_last <= 0; state -> IDLE, unless a new command is accepted in the same cycle.
- RUN, no out_ready: all outputs hold stable (AXI-style).

Handshake and timing:
- in_ready = (state == IDLE) | (state == RUN & rem == 0 & out_ready). This is a combinational path from out_ready to in_ready.
- Last beat consumed and new command accepted in the same cycle: load the new command, stay in RUN, no bubble.
- Latency: accept at edge N gives out_valid high after edge N (visible in cycle N+1).
- Throughput: 1 beat per cycle while out_ready = 1.
- Command fields are sampled only on accept; changes at other times are ignored.

Datapath:
- A single rotate-stage instance. Its input mux selects (in_data, eff_amt) on accept, otherwise (out_data, step).
- Left rotate is implemented as a right rotate by eff_amt = (0 - in_amt) mod 2^AMT_W.
- in_amt = 0: all beats equal in_data.
- in_count = 2^CNT_W-1: 2^CNT_W beats; rem never wraps.

Optional Feature:
- Macro: ROT_BURST_LEFT_EN.
- Defined: in_dir = 1 selects left rotation via eff_amt negation.
- Undefined: in_dir is ignored, all rotation is right, and the negation logic is not synthesised.

Decomposition:
- Package rot_pkg: DATA_W, AMT_W constants; state enum {IDLE, RUN}; function neg_amt(amt).
- Sub-module: reuse the existing barrel_shifter_stage_r as the single combinational rotate instance.
- Only the input mux, counter and FSM are new.

Test Plan:
- Single beat: reset, then data 0x81, amt 1, count 0, out_ready = 1 → one beat 0xC0 with out_last = 1; in_ready back high next cycle.
- Burst: data 0x01, amt 1, count 3 → 0x80, 0x40, 0x20, 0x10 on consecutive cycles; out_last only on 0x10.
- Backpressure: same burst with out_ready low for 3 cycles after the first beat → 0x80 held stable with out_valid = 1; sequence unchanged afterward.
- Direction: data 0x01, amt 3, count 2, dir 1 → with macro 0x08, 0x40, 0x02; without macro 0x20, 0x04, 0x80.
- Back-to-back: second command (0xF0, amt 4, count 0) valid during the last beat of a first burst → accepted that cycle; 0x0F follows with no idle cycle.
- Reset mid-burst: reset_n low during beat 2 of a count-5 burst → next cycle out_valid = 0, in_ready = 1, out_data = 0.
